// File: rtl/icache_pkg.sv
// Shared icache constants: FSM encodings, geometry defaults and the I/O region test.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int INDEX_BITS_DEF = 7;
    localparam int ADDR_BITS_DEF  = 18;

    // pc[17:16] == IO_REGION selects the memory-mapped I/O window
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic int tag_bits(input int index_bits, input int addr_bits);
        return addr_bits - index_bits - 2;
    endfunction

    function automatic logic is_uncacheable(input logic [31:0] pc);
        return pc[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: registered write port, combinational hit/data read, valid clear on rst.
// Writes are only issued by the owning FSM, which never looks up the index it is filling.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [31:0]           i_wr_dat,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    input  logic [TAG_BITS-1:0]   i_rd_tag,
    output logic                  o_hit,
    output logic [31:0]           o_rd_dat
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: a cleared valid bit masks whatever they hold.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_dat;
        end
    end

    assign o_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_dat = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache: hit answers in 1 cycle, miss answers 1 cycle after mem_ready_i.
// Fetch holds if_req_i until if_ready_o; rdy low freezes all state and ignores mem_ready_i.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,
    output logic [31:0] if_inst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_inst_i
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS, ADDR_BITS);

    state_t      r_state;
    logic [31:0] r_req_pc;

    logic                  w_hit;
    logic [31:0]           w_rd_dat;
    logic                  w_fill_we;
    logic                  w_lookup_hit;
    logic                  w_fill_done;
    logic                  w_fill_match;

    assign w_lookup_hit = w_hit && !is_uncacheable(if_pc_i);
    assign w_fill_done  = (r_state == ST_FILL) && mem_ready_i;
    assign w_fill_match = if_req_i && (if_pc_i == r_req_pc);
    // A returned word is installed even if fetch has moved on.
    assign w_fill_we    = !rst && rdy && w_fill_done && !is_uncacheable(r_req_pc);

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_fill_we),
        .i_wr_idx (r_req_pc[INDEX_BITS+1:2]),
        .i_wr_tag (r_req_pc[ADDR_BITS-1:INDEX_BITS+2]),
        .i_wr_dat (mem_inst_i),
        .i_rd_idx (if_pc_i[INDEX_BITS+1:2]),
        .i_rd_tag (if_pc_i[ADDR_BITS-1:INDEX_BITS+2]),
        .o_hit    (w_hit),
        .o_rd_dat (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_pc   <= '0;
            if_ready_o <= 1'b0;
            if_inst_o  <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (if_req_i) begin
                        if (w_lookup_hit) begin
                            if_inst_o  <= w_rd_dat;
                            if_ready_o <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_req_pc   <= if_pc_i;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= {if_pc_i[31:2], 2'b00};
                            r_state    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        if (w_fill_match) begin
                            if_inst_o  <= mem_inst_i;
                            if_ready_o <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RESP: begin
                    if_ready_o <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    if_ready_o <= 1'b0;
                    mem_req_o  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table of fetches plus hand sequences for redirect, stall and reset.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        if_ready_o;
    logic [31:0] if_inst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_inst_i;

    icache dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .if_req_i    (if_req_i),
        .if_pc_i     (if_pc_i),
        .if_ready_o  (if_ready_o),
        .if_inst_o   (if_inst_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready_i),
        .mem_inst_i  (mem_inst_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          miss;
        int          delay;
    } vec_t;

    vec_t vecs[12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every if_ready_o pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (if_ready_o) begin
            check32("ready_without_memreq", {31'b0, mem_req_o}, 32'd0);
            if (exp_q.size() == 0) begin
                check32("unexpected_ready", {31'b0, if_ready_o}, 32'd0);
            end else begin
                check32("if_inst", if_inst_o, exp_q.pop_front());
            end
        end
    end

    task automatic wait_resp(input logic [31:0] pc, input logic [31:0] inst,
                             input bit exp_miss, input int delay);
        int cyc;
        int cnt;
        bit got;
        bit saw;
        cyc = 0;
        cnt = 0;
        got = 1'b0;
        saw = 1'b0;
        while (!got && cyc < 40) begin
            step();
            cyc++;
            mem_ready_i = 1'b0;
            if (if_ready_o) begin
                got = 1'b1;
            end else if (mem_req_o && !saw) begin
                cnt++;
                if (cnt == 1) check32("mem_addr", mem_addr_o, {pc[31:2], 2'b00});
                if (cnt >= delay) begin
                    mem_ready_i = 1'b1;
                    mem_inst_i  = inst;
                    saw         = 1'b1;
                end
            end
        end
        if_req_i = 1'b0;
        check32("served", {31'b0, got}, 32'd1);
        check32("miss", {31'b0, saw}, {31'b0, exp_miss});
        check32("latency", cyc, exp_miss ? delay + 1 : 1);
    endtask

    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] inst,
                             input bit exp_miss, input int delay);
        step();
        if_req_i = 1'b1;
        if_pc_i  = pc;
        exp_q.push_back(inst);
        wait_resp(pc, inst, exp_miss, delay);
    endtask

    task automatic check_idle_outputs(input string tag);
        check32({tag, "_if_ready"}, {31'b0, if_ready_o}, 32'd0);
        check32({tag, "_if_inst"},  if_inst_o,            32'd0);
        check32({tag, "_mem_req"},  {31'b0, mem_req_o},  32'd0);
        check32({tag, "_mem_addr"}, mem_addr_o,           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0040, 32'h00A0_0093, 1'b1, 5};
        vecs[1]  = '{32'h0000_0040, 32'h00A0_0093, 1'b0, 0};
        vecs[2]  = '{32'h0000_0240, 32'h1234_5678, 1'b1, 2};
        vecs[3]  = '{32'h0000_0040, 32'h00A0_0093, 1'b1, 3};
        vecs[4]  = '{32'h0000_0240, 32'h1234_5678, 1'b1, 1};
        vecs[5]  = '{32'h0003_0000, 32'hDEAD_BEEF, 1'b1, 2};
        vecs[6]  = '{32'h0003_0000, 32'hCAFE_F00D, 1'b1, 2};
        vecs[7]  = '{32'h0001_FFFC, 32'h0BAD_F00D, 1'b1, 1};
        vecs[8]  = '{32'h0001_FFFC, 32'h0BAD_F00D, 1'b0, 0};
        vecs[9]  = '{32'h0000_004B, 32'h5555_AAAA, 1'b1, 1};
        vecs[10] = '{32'h0000_0048, 32'h5555_AAAA, 1'b0, 0};
        vecs[11] = '{32'h0000_0240, 32'h1234_5678, 1'b0, 0};

        rst         = 1'b1;
        rdy         = 1'b1;
        if_req_i    = 1'b0;
        if_pc_i     = '0;
        mem_ready_i = 1'b0;
        mem_inst_i  = '0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_fetch(vecs[i].pc, vecs[i].inst, vecs[i].miss, vecs[i].delay);
        end

        // Redirect during fill: the 0x100 word is installed but never forwarded.
        step();
        if_req_i = 1'b1;
        if_pc_i  = 32'h0000_0100;
        step();
        check32("redir_mem_req", {31'b0, mem_req_o}, 32'd1);
        check32("redir_mem_addr", mem_addr_o, 32'h0000_0100);
        if_pc_i = 32'h0000_0200;
        step();
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'hAAAA_0100;
        step();
        mem_ready_i = 1'b0;
        check32("redir_no_ready", {31'b0, if_ready_o}, 32'd0);
        check32("redir_req_drop", {31'b0, mem_req_o}, 32'd0);
        exp_q.push_back(32'hBBBB_0200);
        wait_resp(32'h0000_0200, 32'hBBBB_0200, 1'b1, 1);
        run_fetch(32'h0000_0100, 32'hAAAA_0100, 1'b0, 0);

        // rdy stall mid-fill with a memory pulse that must be ignored.
        step();
        if_req_i = 1'b1;
        if_pc_i  = 32'h0000_0380;
        step();
        check32("stall_mem_req0", {31'b0, mem_req_o}, 32'd1);
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            mem_ready_i = (s == 0);
            mem_inst_i  = 32'h1111_1111;
            check32("stall_mem_req", {31'b0, mem_req_o}, 32'd1);
            check32("stall_mem_addr", mem_addr_o, 32'h0000_0380);
            check32("stall_if_ready", {31'b0, if_ready_o}, 32'd0);
        end
        mem_ready_i = 1'b0;
        rdy = 1'b1;
        exp_q.push_back(32'h2222_2222);
        wait_resp(32'h0000_0380, 32'h2222_2222, 1'b1, 2);
        run_fetch(32'h0000_0380, 32'h2222_2222, 1'b0, 0);

        // Reset clears contents and outputs.
        run_fetch(32'h0000_0000, 32'h0000_0013, 1'b1, 1);
        run_fetch(32'h0000_0004, 32'h0000_0093, 1'b1, 1);
        run_fetch(32'h0000_0000, 32'h0000_0013, 1'b0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("rst_after_fill");
        run_fetch(32'h0000_0000, 32'h0000_0113, 1'b1, 2);
        run_fetch(32'h0000_0004, 32'h0000_0193, 1'b1, 1);

        // Reset mid-fill, with a memory pulse in the reset cycle.
        step();
        if_req_i = 1'b1;
        if_pc_i  = 32'h0000_0008;
        step();
        check32("midrst_mem_req", {31'b0, mem_req_o}, 32'd1);
        rst         = 1'b1;
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'hFFFF_0008;
        step();
        check32("midrst_mem_req_off", {31'b0, mem_req_o}, 32'd0);
        check32("midrst_if_ready", {31'b0, if_ready_o}, 32'd0);
        rst         = 1'b0;
        mem_ready_i = 1'b0;
        if_req_i    = 1'b0;
        run_fetch(32'h0000_0008, 32'h0000_0213, 1'b1, 1);

        step();
        step();
        check32("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
